// File: rtl/mem_access_pkg.sv
// Shared definitions for the load/store memory access unit: width codes,
// FSM states, default address limit and the request legality check.
package mem_access_pkg;

   localparam logic [1:0] WIDTH_BYTE    = 2'd0;
   localparam logic [1:0] WIDTH_HALF    = 2'd1;
   localparam logic [1:0] WIDTH_WORD    = 2'd2;
   localparam logic [1:0] WIDTH_ILLEGAL = 2'd3;

   localparam logic [31:0] DEFAULT_ADDR_LIMIT = 32'h0E00_0000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_READ,
      ST_CAPTURE,
      ST_RESP
   } state_t;

   // End address is computed on 33 bits so accesses near 4 GiB cannot wrap
   // back into the legal range.
   function automatic logic access_error(input logic [1:0]  width,
                                         input logic [31:0] addr,
                                         input logic [31:0] limit);
      logic        bad_align;
      logic [32:0] end_addr;
      case (width)
         WIDTH_BYTE: bad_align = 1'b0;
         WIDTH_HALF: bad_align = addr[0];
         WIDTH_WORD: bad_align = |addr[1:0];
         default:    bad_align = 1'b1;
      endcase
      end_addr = {1'b0, addr} + (33'd1 << width);
      return bad_align | (end_addr > {1'b0, limit});
   endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the loaded byte/half/word from the data bus and sign- or
// zero-extends it to 32 bits.
module load_extend
   import mem_access_pkg::*;
(
   input  logic [31:0] bus_word,
   input  logic [1:0]  width,
   input  logic        is_signed,
   output logic [31:0] result
);

   always_comb begin
      result = bus_word;
      case (width)
         WIDTH_BYTE: result = {{24{is_signed & bus_word[7]}}, bus_word[7:0]};
         WIDTH_HALF: result = {{16{is_signed & bus_word[15]}}, bus_word[15:0]};
         default:    result = bus_word;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit driving a shared tri-state memory bus.
//
// state   | meaning
// IDLE    | ready; accepts and validates a request
// WRITE   | store cycle, unit drives mem_data
// READ    | load address/enable cycle, bus released
// CAPTURE | enable dropped, load data sampled at the closing edge
// RESP    | one-cycle rsp_valid pulse
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter logic [31:0] ADDR_LIMIT = DEFAULT_ADDR_LIMIT
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_width,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_error,
   output logic [31:0] mem_addr,
   output logic        mem_enable,
   output logic        mem_write_n,
   output logic [1:0]  mem_width,
   inout  wire  [31:0] mem_data
);

   state_t      state;
   logic [1:0]  lat_width;
   logic        lat_signed;
   logic [31:0] lat_wdata;
   logic        bus_drive;
   logic [31:0] load_result;

   assign req_ready = (state == ST_IDLE);
   assign mem_data  = bus_drive ? lat_wdata : 32'bz;

   load_extend u_load_extend (
      .bus_word  (mem_data),
      .width     (lat_width),
      .is_signed (lat_signed),
      .result    (load_result)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         lat_width   <= WIDTH_BYTE;
         lat_signed  <= 1'b0;
         lat_wdata   <= '0;
         bus_drive   <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_error   <= 1'b0;
         rsp_rdata   <= '0;
         mem_addr    <= '0;
         mem_enable  <= 1'b0;
         mem_write_n <= 1'b1;
         mem_width   <= WIDTH_BYTE;
      end else begin
         rsp_valid <= 1'b0;
         rsp_error <= 1'b0;
         rsp_rdata <= '0;
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  lat_width  <= req_width;
                  lat_signed <= req_signed;
                  lat_wdata  <= req_wdata;
                  if (access_error(req_width, req_addr, ADDR_LIMIT)) begin
                     state     <= ST_RESP;
                     rsp_valid <= 1'b1;
                     rsp_error <= 1'b1;
                  end else begin
                     state       <= req_write ? ST_WRITE : ST_READ;
                     mem_enable  <= 1'b1;
                     mem_write_n <= ~req_write;
                     mem_addr    <= req_addr;
                     mem_width   <= req_width;
                     bus_drive   <= req_write;
                  end
               end
            end
            ST_WRITE: begin
               state       <= ST_RESP;
               rsp_valid   <= 1'b1;
               bus_drive   <= 1'b0;
               mem_enable  <= 1'b0;
               mem_write_n <= 1'b1;
               mem_addr    <= '0;
               mem_width   <= WIDTH_BYTE;
            end
            ST_READ: begin
               state      <= ST_CAPTURE;
               mem_enable <= 1'b0;
               mem_addr   <= '0;
               mem_width  <= WIDTH_BYTE;
            end
            ST_CAPTURE: begin
               state     <= ST_RESP;
               rsp_valid <= 1'b1;
               rsp_rdata <= load_result;
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus randomized bench for mem_access_unit with a byte-array
// memory model and a bus probe that exposes any stray driver on mem_data.
module tb_mem_access_unit;

   localparam logic [31:0] LIMIT = 32'h0E00_0000;

   typedef enum {P_WRITE, P_READ, P_CAPTURE, P_RESP, P_IDLE} phase_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [1:0]  req_width = 2'd0;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_error;
   logic [31:0] mem_addr;
   logic        mem_enable;
   logic        mem_write_n;
   logic [1:0]  mem_width;
   wire  [31:0] mem_data;

   logic        tb_drv_en = 1'b1;
   logic [31:0] tb_drv_val = 32'h5A5A_A5A5;
   assign mem_data = tb_drv_en ? tb_drv_val : 32'bz;

   int n_assert = 0;
   int n_fail   = 0;
   logic [7:0] mem [longint];

   always #5 clk = ~clk;

   mem_access_unit #(.ADDR_LIMIT(LIMIT)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_width   (req_width),
      .req_signed  (req_signed),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .rsp_error   (rsp_error),
      .mem_addr    (mem_addr),
      .mem_enable  (mem_enable),
      .mem_write_n (mem_write_n),
      .mem_width   (mem_width),
      .mem_data    (mem_data)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] mem_rd(input longint a);
      if (mem.exists(a)) return mem[a];
      return 8'((a * 37 + 11) & 255);
   endfunction

   function automatic logic [31:0] bus_word(input logic [31:0] a);
      longint b;
      b = longint'(a);
      return {mem_rd(b + 3), mem_rd(b + 2), mem_rd(b + 1), mem_rd(b)};
   endfunction

   function automatic logic model_err(input logic [1:0] wd, input logic [31:0] a);
      longint size;
      size = longint'(1) << wd;
      if (wd == 2'd3) return 1'b1;
      if ((longint'(a) % size) != 0) return 1'b1;
      return (longint'(a) + size) > longint'(LIMIT);
   endfunction

   function automatic logic [31:0] model_load(input logic [1:0] wd, input logic sgn, input logic [31:0] a);
      logic [31:0]        w;
      logic signed [7:0]  b;
      logic signed [15:0] h;
      w = bus_word(a);
      b = w[7:0];
      h = w[15:0];
      if (wd == 2'd0) return sgn ? 32'(int'(b)) : {24'd0, w[7:0]};
      if (wd == 2'd1) return sgn ? 32'(int'(h)) : {16'd0, w[15:0]};
      return w;
   endfunction

   task automatic check_quiet(input string tag);
      check({tag, "_ready"}, 32'(req_ready), 32'd1);
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, "_enable"}, 32'(mem_enable), 32'd0);
      check({tag, "_write_n"}, 32'(mem_write_n), 32'd1);
      check({tag, "_bus"}, mem_data, tb_drv_val);
   endtask

   task automatic idle_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         tb_drv_en  = 1'b1;
         tb_drv_val = $urandom;
         @(negedge clk);
         check_quiet("gap");
      end
   endtask

   // Called at a negedge with the unit idle; returns at the negedge of the
   // idle cycle following the response.
   task automatic do_req(input logic w, input logic [1:0] wd, input logic sgn,
                         input logic [31:0] a, input logic [31:0] wdata);
      logic        err;
      logic [31:0] exp_rd;
      phase_t      ph [$];
      err    = model_err(wd, a);
      exp_rd = (err || w) ? 32'd0 : model_load(wd, sgn, a);
      if (err)    ph = '{P_RESP, P_IDLE};
      else if (w) ph = '{P_WRITE, P_RESP, P_IDLE};
      else        ph = '{P_READ, P_CAPTURE, P_RESP, P_IDLE};
      if (!err && w)
         for (int i = 0; i < (1 << wd); i++) mem[longint'(a) + i] = wdata[8*i +: 8];

      req_valid  = 1'b1;
      req_write  = w;
      req_width  = wd;
      req_signed = sgn;
      req_addr   = a;
      req_wdata  = wdata;
      check("issue_ready", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid  = 1'b0;
      req_write  = 1'($urandom);
      req_width  = 2'($urandom);
      req_signed = 1'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;

      for (int i = 0; i < ph.size(); i++) begin
         if (ph[i] == P_WRITE) tb_drv_en = 1'b0;
         else begin
            tb_drv_en  = 1'b1;
            tb_drv_val = (ph[i] == P_READ || ph[i] == P_CAPTURE) ? bus_word(a) : $urandom;
         end
         @(negedge clk);
         check("ready", 32'(req_ready), 32'(ph[i] == P_IDLE));
         check("rsp_valid", 32'(rsp_valid), 32'(ph[i] == P_RESP));
         check("enable", 32'(mem_enable), 32'(ph[i] == P_WRITE || ph[i] == P_READ));
         check("write_n", 32'(mem_write_n), 32'(ph[i] != P_WRITE));
         if (ph[i] == P_WRITE || ph[i] == P_READ) begin
            check("mem_addr", mem_addr, a);
            check("mem_width", 32'(mem_width), 32'(wd));
         end
         if (ph[i] == P_WRITE) check("bus_wdata", mem_data, wdata);
         else                  check("bus_released", mem_data, tb_drv_val);
         if (ph[i] == P_RESP) begin
            check("rsp_error", 32'(rsp_error), 32'(err));
            check("rsp_rdata", rsp_rdata, exp_rd);
         end
         if (i != ph.size() - 1) begin
            @(posedge clk); #1;
         end
      end
   endtask

   initial begin
      #2 reset = 1'b0;
      #1;
      check_quiet("rst_async");
      @(posedge clk);
      @(negedge clk);
      check_quiet("rst_hold");
      check("rst_error", 32'(rsp_error), 32'd0);
      check("rst_rdata", rsp_rdata, 32'd0);
      check("rst_addr", mem_addr, 32'd0);
      check("rst_width", 32'(mem_width), 32'd0);
      reset = 1'b1;
      idle_cycles(2);

      do_req(1'b1, 2'd2, 1'b0, 32'h0001_0000, 32'hDEAD_BEEF);
      do_req(1'b0, 2'd2, 1'b0, 32'h0001_0000, 32'h0);
      do_req(1'b1, 2'd0, 1'b0, 32'h0001_0003, 32'h1234_5680);
      do_req(1'b0, 2'd0, 1'b1, 32'h0001_0003, 32'h0);
      do_req(1'b0, 2'd0, 1'b0, 32'h0001_0003, 32'h0);
      do_req(1'b0, 2'd1, 1'b1, 32'h0001_0002, 32'h0);

      do_req(1'b0, 2'd1, 1'b0, 32'h0001_0001, 32'h0);
      do_req(1'b1, 2'd2, 1'b0, 32'h0001_0002, 32'h1111_2222);
      do_req(1'b0, 2'd3, 1'b0, 32'h0001_0000, 32'h0);

      do_req(1'b1, 2'd2, 1'b0, LIMIT - 32'd4, 32'hCAFE_F00D);
      do_req(1'b0, 2'd2, 1'b0, LIMIT - 32'd4, 32'h0);
      do_req(1'b0, 2'd2, 1'b0, LIMIT - 32'd2, 32'h0);
      do_req(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'h0);
      do_req(1'b0, 2'd0, 1'b1, LIMIT - 32'd1, 32'h0);
      do_req(1'b0, 2'd0, 1'b0, LIMIT, 32'h0);
      do_req(1'b0, 2'd1, 1'b1, LIMIT - 32'd2, 32'h0);

      // Reset while the load is in its READ cycle.
      req_valid = 1'b1; req_write = 1'b0; req_width = 2'd2; req_addr = 32'h0001_0000;
      @(posedge clk); #1;
      req_valid  = 1'b0;
      tb_drv_val = $urandom;
      @(negedge clk);
      check("mid_rst_enable_before", 32'(mem_enable), 32'd1);
      #1 reset = 1'b0;
      #1;
      check_quiet("mid_rst");
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      idle_cycles(4);

      for (int n = 0; n < 60; n++) begin
         logic        w, sgn;
         logic [1:0]  wd;
         logic [31:0] a;
         int          sel;
         w   = 1'($urandom);
         sgn = 1'($urandom);
         wd  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         sel = $urandom_range(0, 9);
         if (sel < 7)      a = 32'h0001_0000 + $urandom_range(0, 31);
         else if (sel < 9) a = LIMIT - 32'($urandom_range(0, 8));
         else              a = $urandom;
         do_req(w, wd, sgn, a, $urandom);
         idle_cycles($urandom_range(0, 2));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter ADDR_LIMIT, default 32'h0E000000, SHALL be the exclusive upper bound of legal byte addresses.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 reset  input  1  SHALL be asynchronous and active-low (0 = in reset).
REQ-004 req_valid  input  1  SHALL mean a load/store request is presented.
REQ-005 req_ready  output  1  SHALL mean a request is accepted on this edge when req_valid=1.
REQ-006 req_write  input  1  SHALL select store (1) or load (0).
REQ-007 req_width  input  2  SHALL encode 0=byte, 1=half, 2=word, 3=illegal.
REQ-008 req_signed  input  1  SHALL select sign-extension (1) or zero-extension (0) for loads.
REQ-009 req_addr  input  32  SHALL be the byte address.
REQ-010 req_wdata  input  32  SHALL carry store data, right-justified.
REQ-011 rsp_valid  output  1  SHALL be a one-cycle completion pulse.
REQ-012 rsp_rdata  output  32  SHALL carry extended load data; 0 for stores and errors.
REQ-013 rsp_error  output  1  SHALL flag a rejected request, qualified by rsp_valid.
REQ-014 mem_addr  output  32  SHALL drive the memory data-port address.
REQ-015 mem_enable  output  1  SHALL drive the memory data-port enable.
REQ-016 mem_write_n  output  1  SHALL drive the memory write strobe, 0 = write, 1 = read.
REQ-017 mem_width  output  2  SHALL drive the memory access width, same encoding as req_width.
REQ-018 mem_data  inout  32  SHALL be the shared memory data bus.

Function
REQ-019 FSM states SHALL be IDLE, WRITE, READ, CAPTURE, RESP; req_ready SHALL be 1 only in IDLE.
REQ-020 Acceptance SHALL latch all req_* fields; later req_* changes SHALL NOT affect the transaction.
REQ-021 A request SHALL be an error if width=3, half with addr[0]=1, word with addr[1:0]!=0, or addr+size > ADDR_LIMIT (33-bit compare, no wrap-around).
REQ-022 Error path: IDLE->RESP with no bus activity; rsp_valid=1 and rsp_error=1 one cycle after acceptance.
REQ-023 Store path: IDLE->WRITE->RESP; in WRITE, mem_enable=1, mem_write_n=0, mem_width and mem_addr from latched request; mem_data driven with latched wdata; rsp_valid 2 cycles after acceptance.
REQ-024 Load path: IDLE->READ->CAPTURE->RESP; READ: mem_enable=1, mem_write_n=1; CAPTURE: mem_enable=0, mem_data sampled at the closing edge; rsp_valid 3 cycles after acceptance.
REQ-025 mem_data SHALL be high-Z in every state except WRITE.
REQ-026 mem_enable SHALL be 0 and mem_write_n SHALL be 1 outside WRITE/READ.
REQ-027 Load data SHALL be taken from bus bits [7:0] (byte), [15:0] (half), or [31:0] (word), then extended per latched req_signed; word loads SHALL NOT be extended.
REQ-028 RESP SHALL last exactly one cycle and return to IDLE; there SHALL be no response backpressure.
REQ-029 Back-to-back requests: the next acceptance SHALL occur no earlier than the cycle after RESP.

Reset
REQ-030 While reset=0: state=IDLE, req_ready=1, rsp_valid=0, rsp_error=0, rsp_rdata=0, mem_addr=0, mem_enable=0, mem_write_n=1, mem_width=0, mem_data=high-Z.
REQ-031 Reset asserted mid-transaction SHALL drop mem_enable immediately (asynchronously) and abandon the transaction with no response.

Structure
REQ-032 Shared package mem_access_pkg SHALL hold the width encodings (WIDTH_BYTE/HALF/WORD), the FSM state enum, and the default ADDR_LIMIT.
REQ-033 Load extension SHALL be a sub-module load_extend (inputs: bus word, width, signed; output: 32-bit result).

Verification
REQ-034 Store word 0xDEADBEEF at 0x10000, then load word -> WRITE cycle shows enable=1/write_n=0/width=2; load rsp_rdata=0xDEADBEEF, rsp_valid 3 cycles after acceptance.
REQ-035 Memory byte 0x80 at 0x10003: lb signed -> 0xFFFFFF80; lbu -> 0x00000080.
REQ-036 Half at 0x10001, word at 0x10002, width=3 -> rsp_error=1 one cycle after acceptance; mem_enable never asserted.
REQ-037 Word at ADDR_LIMIT-4 -> OK; word at ADDR_LIMIT-2 and at 0xFFFFFFFC -> rsp_error=1 (no wrap).
REQ-038 Reset pulled low in READ -> mem_enable=0 in the same cycle, no rsp_valid, req_ready=1 after release.
REQ-039 Bus check -> mem_data high-Z in all cycles except WRITE (bench checks for X/contention).
